traffic_phase_ctrl: RTL and testbench

TRAFFIC_PHASE_CTRL -- requirements
Module: traffic_phase_ctrl

---
 rtl/traffic_phase_ctrl.sv | 143 ++++++++++++++
 tb/tb_traffic_phase_ctrl.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/traffic_phase_ctrl.sv
// Cyclic traffic-light phase controller: ALL_RED -> GREEN -> YELLOW per board, round robin.
// Optional macro DEMAND_SKIP_EN: choose the next board from the req flags and idle in ALL_RED when none is set.
module traffic_phase_ctrl #(
    parameter int NUM_BOARDS   = 4,
    parameter int GREEN_TICKS  = 5,
    parameter int YELLOW_TICKS = 2,
    parameter int ALLRED_TICKS = 1,
    localparam int SEL_W = (NUM_BOARDS <= 2) ? 1 : $clog2(NUM_BOARDS),
    localparam int MAX_D = (GREEN_TICKS > YELLOW_TICKS)
                         ? ((GREEN_TICKS > ALLRED_TICKS) ? GREEN_TICKS : ALLRED_TICKS)
                         : ((YELLOW_TICKS > ALLRED_TICKS) ? YELLOW_TICKS : ALLRED_TICKS),
    localparam int CNT_W = $clog2(MAX_D) + 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    tick,
    input  logic                    hold,
    input  logic [NUM_BOARDS-1:0]   req,
    output logic [SEL_W-1:0]        board_sel,
    output logic [2*NUM_BOARDS-1:0] lights,
    output logic                    phase_done
);

    typedef enum logic [1:0] {
        S_ALL_RED = 2'd0,
        S_GREEN   = 2'd1,
        S_YELLOW  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] G_LAST   = CNT_W'(GREEN_TICKS - 1);
    localparam logic [CNT_W-1:0] Y_LAST   = CNT_W'(YELLOW_TICKS - 1);
    localparam logic [CNT_W-1:0] AR_LAST  = CNT_W'(ALLRED_TICKS - 1);
    localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(NUM_BOARDS - 1);

    state_t                  state, state_n;
    logic [CNT_W-1:0]        count, count_n;
    logic [SEL_W-1:0]        nxt, nxt_n, sel_n;
    logic [2*NUM_BOARDS-1:0] lights_n;
    logic                    done_n;
    logic                    qual;

    assign qual = tick & ~hold;

`ifdef DEMAND_SKIP_EN
    // Rotate req so bit 0 is the board at 'start', then take the lowest set bit.
    function automatic logic [SEL_W-1:0] next_board(input logic [NUM_BOARDS-1:0] r,
                                                    input logic [SEL_W-1:0]      start);
        logic [2*NUM_BOARDS-1:0] rot;
        int off;
        int idx;
        rot = {r, r} >> start;
        off = 0;
        for (int k = NUM_BOARDS - 1; k >= 0; k--) begin
            if (rot[k]) off = k;
        end
        idx = int'(start) + off;
        if (idx >= NUM_BOARDS) idx = idx - NUM_BOARDS;
        return SEL_W'(idx);
    endfunction
`else
    logic unused_req;
    assign unused_req = ^req;
`endif

    always_comb begin
        state_n  = state;
        count_n  = count;
        sel_n    = board_sel;
        nxt_n    = nxt;
        done_n   = 1'b0;
        lights_n = '0;
        if (qual) begin
            case (state)
                S_ALL_RED: begin
                    if (count == AR_LAST) begin
`ifdef DEMAND_SKIP_EN
                        // No demand: park on the terminal count and retry every tick.
                        if (|req) begin
                            state_n = S_GREEN;
                            sel_n   = next_board(req, nxt);
                            count_n = '0;
                        end
`else
                        state_n = S_GREEN;
                        sel_n   = nxt;
                        count_n = '0;
`endif
                    end else begin
                        count_n = count + CNT_W'(1);
                    end
                end
                S_GREEN: begin
                    if (count == G_LAST) begin
                        state_n = S_YELLOW;
                        count_n = '0;
                    end else begin
                        count_n = count + CNT_W'(1);
                    end
                end
                S_YELLOW: begin
                    if (count == Y_LAST) begin
                        state_n = S_ALL_RED;
                        count_n = '0;
                        done_n  = 1'b1;
                        nxt_n   = (board_sel == SEL_LAST) ? '0 : board_sel + SEL_W'(1);
                    end else begin
                        count_n = count + CNT_W'(1);
                    end
                end
                default: begin
                    state_n = S_ALL_RED;
                    count_n = '0;
                end
            endcase
        end
        // Outputs are registered, so decode them from the next state.
        for (int i = 0; i < NUM_BOARDS; i++) begin
            if (SEL_W'(i) == sel_n) begin
                if (state_n == S_GREEN)       lights_n[2*i +: 2] = 2'd2;
                else if (state_n == S_YELLOW) lights_n[2*i +: 2] = 2'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_ALL_RED;
            count      <= '0;
            board_sel  <= '0;
            nxt        <= '0;
            lights     <= '0;
            phase_done <= 1'b0;
        end else begin
            state      <= state_n;
            count      <= count_n;
            board_sel  <= sel_n;
            nxt        <= nxt_n;
            lights     <= lights_n;
            phase_done <= done_n;
        end
    end

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Randomized bench for traffic_phase_ctrl against a phase/ticks-remaining reference model.
module tb_traffic_phase_ctrl;

    localparam int NB = 4;
    localparam int GT = 5;
    localparam int YT = 2;
    localparam int AT = 1;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            tick;
    logic            hold;
    logic [NB-1:0]   req;
    logic [1:0]      board_sel;
    logic [2*NB-1:0] lights;
    logic            phase_done;

    always #5 clk = ~clk;

    traffic_phase_ctrl #(
        .NUM_BOARDS  (NB),
        .GREEN_TICKS (GT),
        .YELLOW_TICKS(YT),
        .ALLRED_TICKS(AT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .tick      (tick),
        .hold      (hold),
        .req       (req),
        .board_sel (board_sel),
        .lights    (lights),
        .phase_done(phase_done)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: phase 0=all red, 1=green, 2=yellow; ticks left in the phase.
    int m_phase, m_rem, m_sel, m_nxt;
    bit m_done;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int pick_board(input logic [NB-1:0] r, input int start);
        for (int k = 0; k < NB; k++) begin
            int b;
            b = (start + k) % NB;
            if (((r >> b) & NB'(1)) != '0) return b;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_phase = 0;
        m_rem   = AT;
        m_sel   = 0;
        m_nxt   = 0;
        m_done  = 0;
    endtask

    task automatic model_step();
        int b;
        m_done = 0;
        if (tick && !hold) begin
            m_rem--;
            if (m_rem == 0) begin
                case (m_phase)
                    0: begin
`ifdef DEMAND_SKIP_EN
                        b = pick_board(req, m_nxt);
`else
                        b = m_nxt;
`endif
                        if (b < 0) m_rem = 1;
                        else begin
                            m_sel   = b;
                            m_phase = 1;
                            m_rem   = GT;
                        end
                    end
                    1: begin
                        m_phase = 2;
                        m_rem   = YT;
                    end
                    default: begin
                        m_phase = 0;
                        m_rem   = AT;
                        m_nxt   = (m_sel + 1) % NB;
                        m_done  = 1;
                    end
                endcase
            end
        end
    endtask

    task automatic check_outputs(input string tag);
        logic [2*NB-1:0] e;
        e = '0;
        if (m_phase == 1)      e = (2*NB)'(2) << (2 * m_sel);
        else if (m_phase == 2) e = (2*NB)'(1) << (2 * m_sel);
        check_eq({tag, "_lights"}, 32'(lights), 32'(e));
        check_eq({tag, "_sel"}, 32'(board_sel), 32'(m_sel));
        check_eq({tag, "_done"}, 32'(phase_done), 32'(m_done));
    endtask

    // Called at a falling edge; applies inputs across one rising edge and checks.
    task automatic cycle(input bit t, input bit h, input logic [NB-1:0] r, input string tag);
        tick = t;
        hold = h;
        req  = r;
        @(posedge clk);
        if (rst_n) model_step();
        else model_reset();
        @(negedge clk);
        check_outputs(tag);
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs("async_rst");
        @(negedge clk);
        check_outputs("rst_held");
        rst_n = 1'b1;
    endtask

    initial begin
        int first_g, second_g;
        bit prev_g;
        logic [NB-1:0] r;

        rst_n = 1'b0;
        tick  = 1'b0;
        hold  = 1'b0;
        req   = '0;
        #1;
        model_reset();
        check_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Free-running ticks: board 0 must come round again 32 cycles later.
        first_g  = -1;
        second_g = -1;
        prev_g   = 0;
        for (int i = 0; i < 40; i++) begin
            cycle(1'b1, 1'b0, '1, "steady");
            if (lights[1:0] == 2'd2 && !prev_g) begin
                if (first_g < 0) first_g = i;
                else if (second_g < 0) second_g = i;
            end
            prev_g = (lights[1:0] == 2'd2);
        end
        check_eq("regreen_gap", 32'(second_g - first_g), 32'd32);

        // Hold in the middle of a green phase.
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, '1, "pre_hold");
        for (int i = 0; i < 10; i++) cycle(1'b1, 1'b1, '1, "hold");
        for (int i = 0; i < 10; i++) cycle(1'b1, 1'b0, '1, "post_hold");

        // Reset in the middle of operation, then tick on every other cycle.
        apply_reset();
        for (int i = 0; i < 80; i++) cycle(i[0] == 1'b0, 1'b0, '1, "half_rate");

        // Random stimulus with occasional asynchronous resets.
        for (int i = 0; i < 3000; i++) begin
            r = NB'($urandom);
            if ($urandom_range(0, 3) == 0) r = '0;
            if ($urandom_range(0, 199) == 0) apply_reset();
            cycle($urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0, r, "rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
